lock_detect_meter: RTL
======================

// Module: lock_detect_meter
// PURPOSE
//  Downstream monitor for one NetworkRing node: compares the node's div8 feedback clock
//  against its reference edge-by-edge over a gated window, reports fb edge count, signed
//  count error and a hysteretic lock flag. Sits between node gen_div8_o and the 7-seg/LED path.
//  One instance per node; all inputs except ref_i/fb_i are synchronous to fpga_clk_i.
// PARAMETERS
//  CNT_WIDTH      12   width of edge counters and freq_count_o
//  GATE_REFS      256  reference rising edges per measurement window (>=2, < 2**CNT_WIDTH)
//  TOL            2    max |fb_count - GATE_REFS| still counted as in-tolerance window
//  LOCK_WINS      4    consecutive in-tol windows needed to assert lock
//  UNLOCK_WINS    2    consecutive out-of-tol windows needed to drop lock
//  TIMEOUT_WIDTH  16   ref-loss watchdog width; lost after 2**TIMEOUT_WIDTH-1 cycles w/o ref edge
// PORTS
//  fpga_clk_i     in   1            sampling clock (258 MHz domain)
//  rst_n_i        in   1            asynchronous, active-low reset
//  enable_i       in   1            0: counters cleared, FSM held in UNLOCKED
//  ref_i          in   1            reference clock, async to fpga_clk_i
//  fb_i           in   1            node gen_div8_o, async to fpga_clk_i
//  freq_count_o   out  CNT_WIDTH    fb rising edges in last completed window
//  error_o        out  CNT_WIDTH+1  signed fb_count - GATE_REFS, last window
//  meas_valid_o   out  1            1-cycle pulse when freq_count_o/error_o update
//  locked_o       out  1            lock flag (FSM in LOCKED)
//  ref_lost_o     out  1            watchdog expired; clears on next ref edge
// BEHAVIOUR
//  Reset (async, rst_n_i=0): all outputs 0, counters 0, sync flops 0, FSM UNLOCKED.
//  Input path: ref_i, fb_i each 2-FF synchronised then rising-edge detected -> 1-cycle
//   ref_edge/fb_edge, 3 cycles after pin edge. Pulses narrower than 1 clk may be missed (ok).
//  Window: ref_cnt counts ref_edge; fb_cnt counts fb_edge, saturates at 2**CNT_WIDTH-1.
//   Window closes on cycle where ref_edge makes ref_cnt reach GATE_REFS. fb_edge on that
//   same cycle counts into the closing window. Next cycle: freq_count_o<=fb_cnt_final,
//   error_o<=fb_cnt_final-GATE_REFS (sign-extended), meas_valid_o=1, both counters restart
//   from 0 (edges in that cycle counted into new window). Latency close->pulse: 1 cycle.
//  First window after reset/enable begins at first ref_edge (discard partial window).
//  in_tol = (|error| <= TOL) evaluated on close; saturated fb_cnt is always out-of-tol.
//  FSM (evaluated at window close only, except abort):
//   UNLOCKED: in_tol -> ACQUIRE (good=1); else stay.
//   ACQUIRE : in_tol -> good++; good==LOCK_WINS -> LOCKED; out-of-tol -> UNLOCKED, good=0.
//   LOCKED  : out-of-tol -> bad++; bad==UNLOCK_WINS -> UNLOCKED; in_tol -> bad=0.
//   locked_o registered = (state==LOCKED); changes same cycle as meas_valid_o.
//  Watchdog: counts cycles since last ref_edge, saturating; at all-ones ref_lost_o=1,
//   FSM -> UNLOCKED, counters cleared, window restarts at next ref_edge (ref_lost_o->0 then).
//  enable_i=0: synchronous clear of counters/FSM/watchdog; freq_count_o/error_o hold last
//   values; meas_valid_o, locked_o, ref_lost_o forced 0. Rising enable: as after reset.
//  Reset mid-window: everything to reset values immediately, no meas_valid_o.
// STRUCTURE
//  Shared pkg constants: LD_ST_UNLOCKED=2'd0, LD_ST_ACQUIRE=2'd1, LD_ST_LOCKED=2'd2.
//  Sub-module edge_sync (2-FF sync + rising-edge pulse, async active-low reset), x2.
//  Top holds window counters, compare, FSM, watchdog.
// TESTING
//  1 ref 10 cyc period, fb identical, GATE_REFS=16 -> freq_count 16, error 0, locked_o after 4th window.
//  2 fb 1 edge/window fast then 5 fast (TOL=2) -> lock kept on 1, error +5 drops lock after 2 windows.
//  3 fb stopped -> freq_count 0, error -GATE_REFS, locked_o falls after UNLOCK_WINS windows.
//  4 ref stopped, TIMEOUT_WIDTH=6 -> ref_lost_o at 63 cycles, locked_o 0; ref resumes -> clears.
//  5 ref and fb edges same cycle at window close -> fb edge in closing window, counts exact.
//  6 rst_n_i low mid-window / enable_i low while LOCKED -> outputs per rules, no stray pulse.

Source files
------------

// File: rtl/lock_detect_meter_pkg.sv
// Shared state encoding and sizing helper for the lock-detect meter.
package lock_detect_meter_pkg;

  typedef enum logic [1:0] {
    LD_ST_UNLOCKED = 2'd0,
    LD_ST_ACQUIRE  = 2'd1,
    LD_ST_LOCKED   = 2'd2
  } ld_state_t;

  // Bits needed to hold a window-run counter that reaches n.
  function automatic int ld_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lock_detect_meter_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// The pulse appears three fpga clocks after the pin edge.
module lock_detect_meter_edge_sync
  import lock_detect_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // sync[1:0] resolve metastability, sync[2] holds the previous settled level.
  logic [2:0] sync;

  // Shift the input through the synchroniser and flag a settled 0->1 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 3'b000;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[1:0], din};
      pulse <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/lock_detect_meter.sv
// Lock detector for one ring node: counts feedback edges over a window of
// GATE_REFS reference edges, reports count and signed error, and runs a
// hysteretic lock FSM plus a reference-loss watchdog.
module lock_detect_meter
  import lock_detect_meter_pkg::*;
#(
  parameter int CNT_WIDTH     = 12,
  parameter int GATE_REFS     = 256,
  parameter int TOL           = 2,
  parameter int LOCK_WINS     = 4,
  parameter int UNLOCK_WINS   = 2,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                 fpga_clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 ref_i,
  input  logic                 fb_i,
  output logic [CNT_WIDTH-1:0] freq_count_o,
  output logic [CNT_WIDTH:0]   error_o,
  output logic                 meas_valid_o,
  output logic                 locked_o,
  output logic                 ref_lost_o
);

  localparam int GOOD_W = ld_cnt_width(LOCK_WINS);
  localparam int BAD_W  = ld_cnt_width(UNLOCK_WINS);

  localparam logic [CNT_WIDTH-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]     GATE     = CNT_WIDTH'(GATE_REFS);
  localparam logic [CNT_WIDTH:0]       TOL_V    = (CNT_WIDTH + 1)'(TOL);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX   = '1;
  localparam logic [GOOD_W-1:0]        GOOD_TOP = GOOD_W'(LOCK_WINS - 1);
  localparam logic [BAD_W-1:0]         BAD_TOP  = BAD_W'(UNLOCK_WINS - 1);

  logic                     ref_edge;
  logic                     fb_edge;
  logic [CNT_WIDTH-1:0]     ref_cnt;
  logic [CNT_WIDTH-1:0]     fb_cnt;
  logic                     running;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  ld_state_t                state;
  logic [GOOD_W-1:0]        good_cnt;
  logic [BAD_W-1:0]         bad_cnt;

  logic [CNT_WIDTH-1:0]     fb_final;
  logic [CNT_WIDTH:0]       err_final;
  logic [CNT_WIDTH:0]       err_abs;
  logic                     in_tol;
  logic                     win_close;
  logic                     wd_expire;

  lock_detect_meter_edge_sync u_ref_sync (
    .clk   (fpga_clk_i),
    .rst_n (rst_n_i),
    .din   (ref_i),
    .pulse (ref_edge)
  );

  lock_detect_meter_edge_sync u_fb_sync (
    .clk   (fpga_clk_i),
    .rst_n (rst_n_i),
    .din   (fb_i),
    .pulse (fb_edge)
  );

  // Closing-window count (a coincident fb edge belongs to this window) and tolerance test.
  always_comb begin
    fb_final  = (fb_edge && (fb_cnt != CNT_MAX)) ? fb_cnt + 1'b1 : fb_cnt;
    err_final = {1'b0, fb_final} - {1'b0, GATE};
    err_abs   = err_final[CNT_WIDTH] ? (~err_final + 1'b1) : err_final;
    in_tol    = (fb_final != CNT_MAX) && (err_abs <= TOL_V);
    win_close = running && ref_edge && (ref_cnt == GATE - 1'b1);
    wd_expire = !ref_edge && (wd_cnt == WD_MAX - 1'b1);
  end

  // Window counters and reference-loss watchdog.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_cnt    <= '0;
      fb_cnt     <= '0;
      running    <= 1'b0;
      wd_cnt     <= '0;
      ref_lost_o <= 1'b0;
    end else if (!enable_i) begin
      ref_cnt    <= '0;
      fb_cnt     <= '0;
      running    <= 1'b0;
      wd_cnt     <= '0;
      ref_lost_o <= 1'b0;
    end else begin
      if (ref_edge) begin
        wd_cnt     <= '0;
        ref_lost_o <= 1'b0;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_expire) begin
        ref_lost_o <= 1'b1;
        running    <= 1'b0;
        ref_cnt    <= '0;
        fb_cnt     <= '0;
      end else if (!running) begin
        // The first ref edge only marks the window start; earlier fb edges are dropped.
        if (ref_edge) begin
          running <= 1'b1;
          ref_cnt <= '0;
          fb_cnt  <= '0;
        end
      end else if (win_close) begin
        ref_cnt <= '0;
        fb_cnt  <= '0;
      end else begin
        if (ref_edge) ref_cnt <= ref_cnt + 1'b1;
        if (fb_edge && (fb_cnt != CNT_MAX)) fb_cnt <= fb_cnt + 1'b1;
      end
    end
  end

  // Lock FSM with registered measurement and lock outputs, stepped once per window.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= LD_ST_UNLOCKED;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      freq_count_o <= '0;
      error_o      <= '0;
      meas_valid_o <= 1'b0;
      locked_o     <= 1'b0;
    end else if (!enable_i) begin
      state        <= LD_ST_UNLOCKED;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      meas_valid_o <= 1'b0;
      locked_o     <= 1'b0;
    end else begin
      meas_valid_o <= win_close;
      if (wd_expire) begin
        state    <= LD_ST_UNLOCKED;
        good_cnt <= '0;
        bad_cnt  <= '0;
        locked_o <= 1'b0;
      end else if (win_close) begin
        freq_count_o <= fb_final;
        error_o      <= err_final;
        case (state)
          LD_ST_UNLOCKED: begin
            if (in_tol) begin
              state    <= LD_ST_ACQUIRE;
              good_cnt <= GOOD_W'(1);
            end
          end
          LD_ST_ACQUIRE: begin
            if (!in_tol) begin
              state    <= LD_ST_UNLOCKED;
              good_cnt <= '0;
            end else if (good_cnt == GOOD_TOP) begin
              state    <= LD_ST_LOCKED;
              good_cnt <= '0;
              bad_cnt  <= '0;
              locked_o <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
          LD_ST_LOCKED: begin
            if (in_tol) begin
              bad_cnt <= '0;
            end else if (bad_cnt == BAD_TOP) begin
              state    <= LD_ST_UNLOCKED;
              bad_cnt  <= '0;
              locked_o <= 1'b0;
            end else begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end
          default: begin
            state    <= LD_ST_UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
